// File: rtl/axi_llc_tag_bist_checker.sv
// Response-side checker for the tag-SRAM March X BIST.
// Queues expected patterns per granted read and compares returned per-way data.
module axi_llc_tag_bist_checker #(
    parameter int unsigned NumWays        = 4,
    parameter int unsigned PatternWidth   = 8,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_i,
    input  logic                              we_i,
    input  logic                              gnt_i,
    input  logic [PatternWidth-1:0]           exp_pattern_i,
    input  logic                              rvalid_i,
    input  logic [NumWays*PatternWidth-1:0]   rdata_i,
    output logic                              stall_o,
    output logic                              pending_o,
    output logic [NumWays-1:0]                bist_res_o,
    output logic                              bist_res_valid_o,
    output logic                              err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [PatternWidth-1:0] fifo_q [MaxOutstanding];
    logic [PatternWidth-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [NumWays-1:0]      res_q, res_d;
    logic                    res_valid_q, res_valid_d;
    logic                    err_q, err_d;

    logic push, pop, empty, full, push_ok, pop_ok;

    always_comb begin
        push    = req_i & gnt_i & ~we_i;
        pop     = rvalid_i;
        empty   = (cnt_q == '0);
        full    = (cnt_q == CntMax);
        pop_ok  = pop & ~empty;
        // A pop frees the slot in the same cycle, so a push when full still lands.
        push_ok = push & (~full | pop_ok);
    end

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        err_d       = err_q;

        if (push_ok) begin
            fifo_d[wr_ptr_q] = exp_pattern_i;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (pop) begin
            res_valid_d = 1'b1;
            for (int w = 0; w < NumWays; w++) begin
                res_d[w] = pop_ok &&
                    (rdata_i[w*PatternWidth +: PatternWidth] == fifo_q[rd_ptr_q]);
            end
        end

        if ((pop && empty) || (push && full && !pop)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            res_q       <= '1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    assign stall_o          = full & ~rvalid_i;
    assign pending_o        = ~empty | res_valid_q;
    assign bist_res_o       = res_q;
    assign bist_res_valid_o = res_valid_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_axi_llc_tag_bist_checker.sv
// Directed table-driven bench for axi_llc_tag_bist_checker (W=4, P=8, depth 2).
module tb_axi_llc_tag_bist_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, gnt, rvalid;
    logic [7:0]  exp_pat;
    logic [31:0] rdata;
    logic        stall, pending, res_valid, err;
    logic [3:0]  res;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_llc_tag_bist_checker #(
        .NumWays(4),
        .PatternWidth(8),
        .MaxOutstanding(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req),
        .we_i(we),
        .gnt_i(gnt),
        .exp_pattern_i(exp_pat),
        .rvalid_i(rvalid),
        .rdata_i(rdata),
        .stall_o(stall),
        .pending_o(pending),
        .bist_res_o(res),
        .bist_res_valid_o(res_valid),
        .err_o(err)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  pat;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        pend;
        logic        vld;
        logic [3:0]  res;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rq, logic w, logic [7:0] p, logic v,
                                logic [31:0] d, logic s, logic pe,
                                logic vl, logic [3:0] r, logic e);
        vec_t x;
        x.req = rq; x.we = w; x.pat = p; x.rv = v; x.rdata = d;
        x.stall = s; x.pend = pe; x.vld = vl; x.res = r; x.err = e;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic drive(logic rq, logic w, logic [7:0] p, logic v, logic [31:0] d);
        @(negedge clk);
        req = rq; we = w; gnt = 1'b1; exp_pat = p; rvalid = v; rdata = d;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 0; we = 0; gnt = 0; exp_pat = 0; rvalid = 0; rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", {28'h0, res}, 32'hF);
        chk("rst_vld", {31'h0, res_valid}, 32'h0);
        chk("rst_pend", {31'h0, pending}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //          req we pat    rv rdata          stall pend vld res     err
        tbl.push_back(mk(1, 0, 8'h00, 0, 32'h0,        0, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'h0,        0, 1, 1, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 0, 32'h0,        0, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'hFFFEFFFF, 0, 1, 1, 4'b1011, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 4'b1011, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 32'h0,        0, 1, 0, 4'b1011, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 0, 32'h0,        0, 1, 0, 4'b1011, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        1, 1, 0, 4'b1011, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'h0,        0, 1, 1, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'hFFFFFFFF, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 0, 8'h5A, 0, 32'h0,        0, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 0, 8'hA5, 0, 32'h0,        0, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 0, 8'h3C, 1, 32'h5A5A5A5A, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        1, 1, 0, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'hA5A5A500, 0, 1, 1, 4'b1110, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'h3C3C3C3C, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 4'b1111, 0));
        tbl.push_back(mk(1, 1, 8'h77, 0, 32'h0,        0, 0, 0, 4'b1111, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 32'h0,        0, 1, 1, 4'b0000, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 4'b0000, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].we, tbl[i].pat, tbl[i].rv, tbl[i].rdata);
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, tbl[i].stall});
            post_edge();
            chk($sformatf("v%0d_pend", i), {31'h0, pending}, {31'h0, tbl[i].pend});
            chk($sformatf("v%0d_vld", i), {31'h0, res_valid}, {31'h0, tbl[i].vld});
            chk($sformatf("v%0d_res", i), {28'h0, res}, {28'h0, tbl[i].res});
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].err});
        end

        // Reset with two reads queued discards them; a later response is an empty pop.
        @(negedge clk); rst = 1'b1; req = 0; rvalid = 0;
        post_edge();
        @(negedge clk); rst = 1'b0;
        chk("seq1_err_clr", {31'h0, err}, 32'h0);
        drive(1, 0, 8'h11, 0, 32'h0); post_edge();
        drive(1, 0, 8'h22, 0, 32'h0); post_edge();
        chk("seq1_full_stall", {31'h0, stall}, 32'h1);
        @(negedge clk); req = 0; rst = 1'b1;
        post_edge();
        chk("seq1_pend_rst", {31'h0, pending}, 32'h0);
        chk("seq1_res_rst", {28'h0, res}, 32'hF);
        @(negedge clk); rst = 1'b0;
        drive(0, 0, 8'h00, 1, 32'h11111111); post_edge();
        chk("seq1_late_err", {31'h0, err}, 32'h1);
        chk("seq1_late_res", {28'h0, res}, 32'h0);
        chk("seq1_late_vld", {31'h0, res_valid}, 32'h1);

        // Push into a full FIFO with no pop: dropped, error flagged.
        @(negedge clk); rst = 1'b1; rvalid = 0; req = 0;
        post_edge();
        @(negedge clk); rst = 1'b0;
        drive(1, 0, 8'h01, 0, 32'h0); post_edge();
        drive(1, 0, 8'h02, 0, 32'h0); post_edge();
        drive(1, 0, 8'h03, 0, 32'h0);
        chk("seq2_stall", {31'h0, stall}, 32'h1);
        post_edge();
        chk("seq2_err", {31'h0, err}, 32'h1);
        drive(0, 0, 8'h00, 1, 32'h01010101); post_edge();
        chk("seq2_pop1", {28'h0, res}, 32'hF);
        drive(0, 0, 8'h00, 1, 32'h02020202); post_edge();
        chk("seq2_pop2", {28'h0, res}, 32'hF);
        drive(0, 0, 8'h00, 0, 32'h0); post_edge();
        chk("seq2_pend", {31'h0, pending}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
